shared_buffer_master: RTL and testbench

- Burst initiator that drives the 64 x 512-bit shared buffer SRAM port (CEN/WEN/A/D/RETN, Q) on behalf of one compute or DMA client.
- Converts a single request (read or write, base address, beat count) into back-to-back SRAM accesses.
- Write data arrives on a valid/ready stream; read data leaves on a valid/ready stream.
- Sits between the client and the shared buffer. It absorbs the buffer's fixed 1-cycle read latency, and the fact that the buffer cannot stall, with a small output FIFO and credit-based issue.

---
 rtl/shared_buffer_master.sv | 187 ++++++++++++++++++
 tb/tb_shared_buffer_master.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_buffer_master.sv
// shared_buffer_master
//   Burst initiator for the 64 x 512-bit shared buffer SRAM. One request
//   (read/write, base address, beats-1) becomes back-to-back SRAM accesses.
//   Write beats arrive on a valid/ready stream. Read beats are returned
//   through a small FIFO that absorbs the SRAM's fixed 1-cycle read latency.
//
// Ports
//   CLK, RSTN              clock, synchronous active-low reset
//   req_valid/req_ready    request handshake (ready only in IDLE)
//   req_write/addr/len     burst direction, first address, beats minus 1
//   wr_valid/ready/data    write beat stream (ready in every WRITE cycle)
//   rd_valid/ready/data    read beat stream (FIFO head)
//   busy, done             not-IDLE flag, one-cycle completion pulse
//   mem_cen/wen/a/d/retn   registered SRAM command outputs
//   mem_q                  SRAM read data, valid the cycle after a read command
module shared_buffer_master #(
    parameter int DATA_W     = 512,
    parameter int ADDR_W     = 6,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              mem_cen,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_retn,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int CRD_W = CNT_W + 2;
    localparam logic [CRD_W-1:0] DEPTH_C  = CRD_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] cnt;
    logic              inflight;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;

    logic              rd_cmd;
    logic              push;
    logic              pop;
    logic [CRD_W-1:0]  credit_use;
    logic              credit_ok;

    // A read command is on the SRAM pins this cycle; its data shows up on
    // mem_q next cycle, when inflight is set and the FIFO captures it.
    assign rd_cmd = !mem_cen && mem_wen;
    assign push   = inflight;
    assign pop    = rd_valid && rd_ready;

    assign rd_valid  = (fifo_count != '0);
    assign rd_data   = fifo_mem[rd_ptr];
    assign busy      = (state != S_IDLE);
    assign wr_ready  = (state == S_WRITE);
    // mem_retn doubles as the "out of reset" flag so req_ready stays low
    // until the first cycle after reset release.
    assign req_ready = (state == S_IDLE) && mem_retn;

    // Entries that will be occupied when a read issued now is captured:
    // current FIFO contents (less the pop happening now), the read already on
    // the pins and the beat being captured. Counting the pop keeps the issue
    // rate up without ever overflowing.
    assign credit_use = CRD_W'(fifo_count) + CRD_W'(rd_cmd) + CRD_W'(inflight)
                        - CRD_W'(pop);
    assign credit_ok  = (credit_use < DEPTH_C);

    // Control FSM and registered SRAM command
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state    <= S_IDLE;
            addr     <= '0;
            cnt      <= '0;
            inflight <= 1'b0;
            done     <= 1'b0;
            mem_cen  <= 1'b1;
            mem_wen  <= 1'b1;
            mem_a    <= '0;
            mem_d    <= '0;
            mem_retn <= 1'b0;
        end else begin
            mem_retn <= 1'b1;
            inflight <= rd_cmd;
            done     <= 1'b0;
            mem_cen  <= 1'b1;
            mem_wen  <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        if (req_write) begin
                            addr  <= req_addr;
                            cnt   <= req_len;
                            state <= S_WRITE;
                        end else begin
                            // The FIFO is always empty in IDLE, so the first
                            // read goes out on the handshake itself; this
                            // saves a cycle of read latency.
                            mem_cen <= 1'b0;
                            mem_a   <= req_addr;
                            addr    <= req_addr + 1'b1;
                            cnt     <= req_len - 1'b1;
                            state   <= (req_len == '0) ? S_DRAIN : S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    if (wr_valid) begin
                        mem_cen <= 1'b0;
                        mem_wen <= 1'b0;
                        mem_a   <= addr;
                        mem_d   <= wr_data;
                        addr    <= addr + 1'b1;
                        cnt     <= cnt - 1'b1;
                        if (cnt == '0) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (credit_ok) begin
                        mem_cen <= 1'b0;
                        mem_a   <= addr;
                        addr    <= addr + 1'b1;
                        cnt     <= cnt - 1'b1;
                        if (cnt == '0) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (fifo_count == '0 && !rd_cmd && !inflight) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read-return FIFO pointers and occupancy
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr] <= mem_q;
    end

endmodule

// File: tb/tb_shared_buffer_master.sv
// Testbench for shared_buffer_master: behavioural SRAM model, directed
// bursts, and a negedge monitor that scores every SRAM write, SRAM read
// address and read beat against queues filled by the stimulus.
module tb_shared_buffer_master;

    localparam int DW = 512;
    localparam int AW = 6;
    localparam int FD = 2;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [AW-1:0] req_addr = '0, req_len = '0;
    logic          wr_valid = 1'b0, wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid, rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic          busy, done;
    logic          mem_cen, mem_wen, mem_retn;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d;
    logic [DW-1:0] mem_q = '0;

    shared_buffer_master #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(FD)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done),
        .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_a(mem_a), .mem_d(mem_d),
        .mem_retn(mem_retn), .mem_q(mem_q)
    );

    always #5 CLK = ~CLK;

    // SRAM model: registered read, zero on non-read cycles
    logic [DW-1:0] sram [64];
    always @(posedge CLK) begin
        if (!mem_cen && !mem_wen) sram[mem_a] <= mem_d;
        if (!mem_cen && mem_wen) mem_q <= sram[mem_a];
        else                     mem_q <= '0;
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          last;
    } wexp_t;

    wexp_t         wexp [$];
    logic [AW-1:0] raexp [$];
    logic [DW-1:0] rdexp [$];
    logic [DW-1:0] ref_mem [64];

    int checks = 0;
    int passes = 0;
    int done_cnt = 0;
    int cyc = 0;
    logic bp = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every event the DUT presents is scored against the queues
    always @(negedge CLK) begin
        if (done) done_cnt++;
        if (mem_wen === 1'b0) chk("wen_implies_cen", DW'(mem_cen), DW'(0));
        if (mem_cen === 1'b0 && mem_wen === 1'b0) begin
            chk("write_expected", DW'(wexp.size() != 0), DW'(1));
            if (wexp.size() != 0) begin
                wexp_t e;
                e = wexp.pop_front();
                chk("write_addr", DW'(mem_a), DW'(e.a));
                chk("write_data", mem_d, e.d);
                chk("write_done", DW'(done), DW'(e.last));
            end
        end
        if (mem_cen === 1'b0 && mem_wen === 1'b1) begin
            chk("read_expected", DW'(raexp.size() != 0), DW'(1));
            if (raexp.size() != 0) chk("read_addr", DW'(mem_a), DW'(raexp.pop_front()));
        end
        if (rd_valid === 1'b1) begin
            chk("beat_expected", DW'(rdexp.size() != 0), DW'(1));
            if (rdexp.size() != 0) begin
                chk("rd_data", rd_data, rdexp[0]);
                if (rd_ready) void'(rdexp.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
        if (bp) rd_ready = (cyc % 3 == 0);
    endtask

    task automatic send_req(input logic w, input logic [AW-1:0] a, input logic [AW-1:0] l);
        int n = 0;
        while (!req_ready && n < 50) begin step(); n++; end
        chk("req_ready_wait", DW'(req_ready), DW'(1));
        req_valid = 1'b1; req_write = w; req_addr = a; req_len = l;
        step();
        req_valid = 1'b0;
    endtask

    task automatic write_burst(input logic [AW-1:0] a, input logic [AW-1:0] l,
                               input logic [DW-1:0] base, input logic [15:0] pat, input int patn);
        int beats = int'(l) + 1;
        int sent = 0;
        int k = 0;
        int dbefore = done_cnt;
        logic v;
        logic [AW-1:0] wa = a;
        send_req(1'b1, a, l);
        while (sent < beats && k < 200) begin
            v = (k < patn) ? pat[k] : 1'b1;
            wr_valid = v;
            wr_data  = base + DW'(sent);
            if (v) begin
                wexp.push_back(wexp_t'{wa, base + DW'(sent), sent == beats - 1});
                ref_mem[wa] = base + DW'(sent);
                wa++;
                sent++;
            end
            step();
            k++;
        end
        wr_valid = 1'b0;
        step();
        chk("wr_done_pulses", DW'(done_cnt - dbefore), DW'(1));
        chk("wr_busy_after", DW'(busy), DW'(0));
        chk("wr_all_seen", DW'(wexp.size()), DW'(0));
    endtask

    task automatic read_burst(input logic [AW-1:0] a, input logic [AW-1:0] l,
                              input logic bpmode, input logic lat);
        int beats = int'(l) + 1;
        int n = 0;
        int dbefore = done_cnt;
        logic [AW-1:0] ai;
        for (int i = 0; i < beats; i++) begin
            ai = a + AW'(i);
            raexp.push_back(ai);
            rdexp.push_back(ref_mem[ai]);
        end
        rd_ready = !bpmode;
        send_req(1'b0, a, l);
        if (lat) begin
            @(negedge CLK); chk("rd_lat_cycle0", DW'(rd_valid), DW'(0));
            @(negedge CLK); chk("rd_lat_cycle1", DW'(rd_valid), DW'(0));
            @(negedge CLK); chk("rd_lat_cycle2", DW'(rd_valid), DW'(1));
            @(posedge CLK); #1;
        end
        bp = bpmode;
        while (done_cnt == dbefore && n < 2000) begin step(); n++; end
        bp = 1'b0;
        rd_ready = 1'b0;
        chk("rd_done_pulses", DW'(done_cnt - dbefore), DW'(1));
        chk("rd_beats_left", DW'(rdexp.size()), DW'(0));
        chk("rd_addrs_left", DW'(raexp.size()), DW'(0));
        chk("rd_valid_after", DW'(rd_valid), DW'(0));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin sram[i] = '0; ref_mem[i] = '0; end

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_mem_cen", DW'(mem_cen), DW'(1));
        chk("rst_mem_wen", DW'(mem_wen), DW'(1));
        chk("rst_mem_a", DW'(mem_a), DW'(0));
        chk("rst_mem_d", mem_d, DW'(0));
        chk("rst_mem_retn", DW'(mem_retn), DW'(0));
        chk("rst_req_ready", DW'(req_ready), DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_done", DW'(done), DW'(0));
        chk("rst_rd_valid", DW'(rd_valid), DW'(0));
        chk("rst_wr_ready", DW'(wr_ready), DW'(0));
        RSTN = 1'b1;
        step();
        chk("rel_mem_retn", DW'(mem_retn), DW'(1));
        chk("rel_req_ready", DW'(req_ready), DW'(1));

        // Basic write / read back with latency check
        write_burst(6'd5, 6'd3, DW'(32'hA), 16'hFFFF, 0);
        read_burst(6'd5, 6'd3, 1'b0, 1'b1);

        // Address wrap 62,63,0,1
        write_burst(6'd62, 6'd3, DW'(32'h100), 16'hFFFF, 0);
        read_burst(6'd62, 6'd3, 1'b0, 1'b0);

        // wr_valid gaps 1,0,0,1,1,0,1
        write_burst(6'd20, 6'd3, DW'(32'h200), 16'b1011001, 7);
        read_burst(6'd20, 6'd3, 1'b0, 1'b0);

        // Full 64-beat burst, read back under 1-in-3 backpressure
        write_burst(6'd10, 6'd63, {16{32'hC0DE_0000}}, 16'hFFFF, 0);
        read_burst(6'd10, 6'd63, 1'b1, 1'b0);

        // Reset mid-read with the FIFO full
        rd_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            raexp.push_back(AW'(i));
            rdexp.push_back(ref_mem[i]);
        end
        send_req(1'b0, 6'd0, 6'd63);
        repeat (8) step();
        chk("full_rd_valid", DW'(rd_valid), DW'(1));
        chk("full_busy", DW'(busy), DW'(1));
        RSTN = 1'b0;
        step();
        raexp.delete();
        rdexp.delete();
        chk("abort_mem_cen", DW'(mem_cen), DW'(1));
        chk("abort_rd_valid", DW'(rd_valid), DW'(0));
        chk("abort_mem_retn", DW'(mem_retn), DW'(0));
        chk("abort_busy", DW'(busy), DW'(0));
        chk("abort_req_ready", DW'(req_ready), DW'(0));
        step();
        RSTN = 1'b1;
        step();
        step();
        chk("post_req_ready", DW'(req_ready), DW'(1));
        write_burst(6'd40, 6'd1, DW'(32'h300), 16'hFFFF, 0);
        read_burst(6'd40, 6'd1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
